plaintext_packer: RTL and testbench

//  Downstream of the decryption top level. Takes the 8-bit plaintext byte stream
//  (data_o/valid_o of the output mux) and packs it into 32-bit words.

---
 rtl/decryption_pkg.sv | 27 ++
 rtl/packer_fifo.sv | 51 +++++
 rtl/plaintext_packer.sv | 139 +++++++++++++
 tb/tb_plaintext_packer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/decryption_pkg.sv
// Shared widths and types for the plaintext output path.
package decryption_pkg;
    localparam int SYS_DWIDTH = 8;
    localparam int MST_DWIDTH = 32;
    localparam int LANES      = MST_DWIDTH / SYS_DWIDTH;

    typedef logic [LANES-1:0] be_t;
    typedef logic [1:0]       lane_idx_t;

    // Packer state doubles as the lane fill count (idx).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL1 = 2'd1,
        FILL2 = 2'd2,
        FILL3 = 2'd3
    } pack_state_e;

    typedef struct packed {
        logic [MST_DWIDTH-1:0] dat;
        be_t                   be;
    } word_t;

    // Byte enables for the first n lanes, MSB-first.
    function automatic be_t lanes_be(input logic [2:0] n);
        return be_t'(~(4'hF >> n));
    endfunction
endpackage

// File: rtl/packer_fifo.sv
// Synchronous first-word-fall-through FIFO; write is accepted when not full or on a same-cycle pop.
// rd_dat_o reads as zero while empty so the consumer never sees stale words.
module packer_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 36,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_vld_i,
    input  logic [WIDTH-1:0] wr_dat_i,
    input  logic             rd_rdy_i,
    output logic             rd_vld_o,
    output logic [WIDTH-1:0] rd_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      cnt_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             pop;
    logic             push;

    assign empty_o  = (wptr_q == rptr_q);
    assign full_o   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign cnt_o    = wptr_q - rptr_q;
    assign rd_vld_o = !empty_o;
    assign rd_dat_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    assign pop    = !empty_o && rd_rdy_i;
    assign push   = wr_vld_i && (!full_o || pop);
    assign wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    assign rptr_d = pop  ? rptr_q + 1'b1 : rptr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= wr_dat_i;
        end
    end
endmodule

// File: rtl/plaintext_packer.sv
// Packs the plaintext byte stream MSB-first into 32-bit words, queues them for a valid/ready consumer.
// Optional PACKER_BYTE_CNT_EN adds byte_cnt_o, a 16-bit count of accepted bytes.
module plaintext_packer
    import decryption_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int AFULL_MARGIN = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst,
    input  logic [SYS_DWIDTH-1:0] data_i,
    input  logic                  valid_i,
    input  logic                  flush_i,
    output logic [MST_DWIDTH-1:0] data_o,
    output be_t                   be_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  ovf_o,
    input  logic                  clr_ovf_i
`ifdef PACKER_BYTE_CNT_EN
    ,
    output logic [15:0]           byte_cnt_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    pack_state_e           state_q, state_d;
    logic [MST_DWIDTH-1:0] acc_q, acc_d;
    logic [MST_DWIDTH-1:0] merged;
    lane_idx_t             lane;
    logic [2:0]            n_after;
    logic                  wr_req;
    word_t                 wr_word;
    word_t                 rd_word;
    logic                  fifo_full, fifo_empty;
    logic [AW:0]           fifo_cnt;
    logic                  wr_drop;
    logic                  busy_q, busy_d;
    logic                  ovf_q, ovf_d;

    assign lane    = 2'd3 - lane_idx_t'(state_q);
    assign n_after = {1'b0, state_q} + {2'b00, valid_i};

    always_comb begin
        merged = acc_q;
        if (valid_i) begin
            merged[int'(lane)*SYS_DWIDTH +: SYS_DWIDTH] = data_i;
        end
    end

    // acc is cleared whenever a word leaves, so unfilled lanes of a partial word read as zero.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        wr_req  = 1'b0;
        wr_word = '0;
        if (n_after == 3'd4 || (flush_i && n_after != 3'd0)) begin
            wr_req      = 1'b1;
            wr_word.dat = merged;
            wr_word.be  = lanes_be(n_after);
            state_d     = EMPTY;
            acc_d       = '0;
        end else if (valid_i) begin
            state_d = pack_state_e'(n_after[1:0]);
            acc_d   = merged;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
        end
    end

    packer_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(word_t))
    ) u_fifo (
        .clk_i    (clk_sys),
        .rst_i    (rst),
        .wr_vld_i (wr_req),
        .wr_dat_i (wr_word),
        .rd_rdy_i (ready_i),
        .rd_vld_o (valid_o),
        .rd_dat_o (rd_word),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .cnt_o    (fifo_cnt)
    );

    assign data_o  = rd_word.dat;
    assign be_o    = rd_word.be;
    assign wr_drop = wr_req && fifo_full && !(!fifo_empty && ready_i);

    assign busy_d = (DEPTH - int'(fifo_cnt)) <= AFULL_MARGIN;
    assign ovf_d  = wr_drop ? 1'b1 : (clr_ovf_i ? 1'b0 : ovf_q);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            busy_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            ovf_q  <= ovf_d;
        end
    end

    assign busy_o = busy_q;
    assign ovf_o  = ovf_q;

`ifdef PACKER_BYTE_CNT_EN
    logic [15:0] byte_cnt_q, byte_cnt_d;

    // A byte whose word is dropped on overflow is not counted.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (clr_ovf_i) begin
            byte_cnt_d = '0;
        end else if (valid_i && !wr_drop) begin
            byte_cnt_d = byte_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            byte_cnt_q <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
        end
    end

    assign byte_cnt_o = byte_cnt_q;
`endif
endmodule

// File: tb/tb_plaintext_packer.sv
// Bench for plaintext_packer: directed table, multi-cycle corner sequences, random stimulus vs a queue model.
module tb_plaintext_packer;
    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk_sys = 1'b0;
    logic        rst, valid_i, flush_i, ready_i, clr_ovf_i;
    logic [7:0]  data_i;
    logic [31:0] data_o;
    logic [3:0]  be_o;
    logic        valid_o, busy_o, ovf_o;
`ifdef PACKER_BYTE_CNT_EN
    logic [15:0] byte_cnt_o;
`endif

    always #5 clk_sys = ~clk_sys;

    plaintext_packer #(.DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .data_o    (data_o),
        .be_o      (be_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .busy_o    (busy_o),
        .ovf_o     (ovf_o),
        .clr_ovf_i (clr_ovf_i)
`ifdef PACKER_BYTE_CNT_EN
        ,
        .byte_cnt_o(byte_cnt_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: list of stored words, list of pending bytes, flags.
    logic [35:0] m_q[$];
    logic [7:0]  m_bytes[$];
    logic        m_busy = 1'b0;
    logic        m_ovf  = 1'b0;
    int          m_bcnt = 0;

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d,
                              input logic f, input logic rd, input logic clr);
        int          sz;
        logic        has_word;
        logic        pop;
        logic        dropped;
        logic [31:0] wd;
        logic [3:0]  wb;
        if (r) begin
            m_q.delete();
            m_bytes.delete();
            m_busy = 1'b0;
            m_ovf  = 1'b0;
            m_bcnt = 0;
            return;
        end
        sz       = m_q.size();
        pop      = (sz > 0) && rd;
        has_word = 1'b0;
        dropped  = 1'b0;
        wd       = '0;
        wb       = '0;
        if (v) m_bytes.push_back(d);
        if (m_bytes.size() == 4 || (f && m_bytes.size() > 0)) begin
            for (int k = 0; k < m_bytes.size(); k++) begin
                wd = wd | (32'(m_bytes[k]) << (24 - 8 * k));
                wb = wb | (4'(1) << (3 - k));
            end
            has_word = 1'b1;
            m_bytes.delete();
        end
        m_busy = (DEPTH - sz) <= MARGIN;
        if (pop) void'(m_q.pop_front());
        if (has_word) begin
            if (m_q.size() < DEPTH) m_q.push_back({wd, wb});
            else dropped = 1'b1;
        end
        if (dropped) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        if (clr) m_bcnt = 0;
        else if (v && !dropped) m_bcnt = (m_bcnt + 1) % 65536;
    endtask

    task automatic cycle(input logic r, input logic v, input logic [7:0] d,
                         input logic f, input logic rd, input logic clr);
        logic [35:0] exp_word;
        rst = r; valid_i = v; data_i = d; flush_i = f; ready_i = rd; clr_ovf_i = clr;
        @(posedge clk_sys);
        model_step(r, v, d, f, rd, clr);
        #1;
        exp_word = '0;
        if (m_q.size() > 0) exp_word = m_q[0];
        check("valid_o", 36'(valid_o), 36'(m_q.size() > 0));
        check("word", {data_o, be_o}, exp_word);
        check("busy_o", 36'(busy_o), 36'(m_busy));
        check("ovf_o", 36'(ovf_o), 36'(m_ovf));
`ifdef PACKER_BYTE_CNT_EN
        check("byte_cnt_o", 36'(byte_cnt_o), 36'(m_bcnt));
`endif
    endtask

    task automatic push_word(input logic [7:0] base, input logic rd_last);
        for (int b = 0; b < 4; b++)
            cycle(1'b0, 1'b1, base + 8'(b), 1'b0, (b == 3) ? rd_last : 1'b0, 1'b0);
    endtask

    task automatic drain(output int popped);
        popped = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            if (!valid_o) break;
            cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            popped++;
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        rd;
        logic        ev;
        logic [31:0] ed;
        logic [3:0]  eb;
    } vec_t;

    vec_t tbl[18];

    initial begin
        int popped;
        tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b0, 1'b1, 32'h11223344, 4'hF};
        tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[5]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[6]  = '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'hAABB0000, 4'hC};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[10] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[11] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[12] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[13] = '{1'b1, 8'h04, 1'b1, 1'b0, 1'b1, 32'h01020304, 4'hF};
        tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0};
        tbl[15] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h5A000000, 4'h8};
        tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 4'h0};

        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
        check("reset_outputs", {data_o, be_o}, 36'h0);

        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].rd, 1'b0);
            check($sformatf("tbl%0d_valid", i), 36'(valid_o), 36'(tbl[i].ev));
            check($sformatf("tbl%0d_word", i), {data_o, be_o}, {tbl[i].ed, tbl[i].eb});
        end

        // Overflow with consumer stalled: busy lags the 6th word by a cycle, 9th word dropped.
        for (int w = 0; w < DEPTH + 1; w++) begin
            push_word(8'(w * 4 + 1), 1'b0);
            if (w == 5) check("busy_lag", 36'(busy_o), 36'h0);
            if (w == 6) check("busy_after_6th", 36'(busy_o), 36'h1);
        end
        check("ovf_set", 36'(ovf_o), 36'h1);
        drain(popped);
        check("stored_words", 36'(popped), 36'(DEPTH));
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("ovf_cleared", 36'(ovf_o), 36'h0);

        // Full FIFO with a pop on the same edge the 9th word completes.
        for (int w = 0; w < DEPTH; w++) push_word(8'(w * 4 + 8'h40), 1'b0);
        push_word(8'hE0, 1'b1);
        check("no_ovf_on_pop", 36'(ovf_o), 36'h0);
        drain(popped);
        check("count_kept", 36'(popped), 36'(DEPTH));

        // Reset mid-word and mid-FIFO.
        for (int w = 0; w < 3; w++) push_word(8'(w * 4 + 8'h80), 1'b0);
        cycle(1'b0, 1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("rst_valid", 36'(valid_o), 36'h0);
        cycle(1'b0, 1'b1, 8'hDE, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hAD, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hBE, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'hEF, 1'b0, 1'b0, 1'b0);
        check("post_rst_word", {data_o, be_o}, {32'hDEADBEEF, 4'hF});
`ifdef PACKER_BYTE_CNT_EN
        check("post_rst_bytes", 36'(byte_cnt_o), 36'd4);
`endif

        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 9) < 7),
                  8'($urandom),
                  ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 9) < ((i / 500) % 2 == 0 ? 2 : 6)),
                  ($urandom_range(0, 19) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
